// File: rtl/chip8_gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chip8_gpu_pkg
// Description : Shared types and constants for the CHIP-8 sprite engine:
//               draw state machine encoding, screen geometry and the default
//               framebuffer base address.
// Revision    : 1.0 - initial release
// ============================================================================
package chip8_gpu_pkg;

    localparam int          SCREEN_W            = 64;
    localparam int          SCREEN_H            = 32;
    localparam int          ROW_BYTES           = 8;
    localparam logic [15:0] DEFAULT_SCREEN_ADDR = 16'h0F00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LRD   = 3'd2,
        ST_LWR   = 3'd3,
        ST_RRD   = 3'd4,
        ST_RWR   = 3'd5,
        ST_NEXT  = 3'd6
    } gpu_state_t;

endpackage
`default_nettype wire

// File: rtl/chip8_gpu_sprite_shifter.sv
`default_nettype none
// ============================================================================
// Module      : sprite_shifter
// Description : Splits a sprite byte across two adjacent screen bytes.
//               left  = sprite >> shift
//               right = sprite << (8 - shift), truncated to 8 bits (0 if shift=0)
// Ports       : sprite [7:0] in, shift [2:0] in, left [7:0] out, right [7:0] out
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_shifter (
    input  logic [7:0] sprite,
    input  logic [2:0] shift,
    output logic [7:0] left,
    output logic [7:0] right
);

    // Shifting the byte down through a 16-bit window yields both halves at
    // once: the top byte is the left part, the bits that fall out the bottom
    // are the right part.
    logic [15:0] window;

    assign window = {sprite, 8'h00} >> shift;
    assign left   = window[15:8];
    assign right  = window[7:0];

endmodule
`default_nettype wire

// File: rtl/chip8_gpu.sv
`default_nettype none
// ============================================================================
// Module      : chip8_gpu
// Description : CHIP-8 sprite drawing engine. XORs `lines` sprite bytes read
//               from shared memory onto the 64x32 framebuffer held in the same
//               memory and reports whether any lit pixel was turned off.
// Ports       : clk, reset (async, active-high)
//               draw/addr/lines/x/y  - request from the CPU
//               ready/collision      - status back to the CPU
//               mem_read/mem_write/mem_addr/mem_write_byte/mem_read_byte
//                                    - single-port memory, 1-cycle read latency
// Config      : GPU_WRAP_EN defined   -> rows wrap mod 32, right byte wraps
//                                        to column 0 of the same row
//               GPU_WRAP_EN undefined -> off-screen rows and the right byte
//                                        past column 7 are clipped
// Revision    : 1.0 - initial release
// ============================================================================
module chip8_gpu
    import chip8_gpu_pkg::*;
#(
    parameter logic [15:0] SCREEN_ADDR = DEFAULT_SCREEN_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        draw,
    input  logic [15:0] addr,
    input  logic [3:0]  lines,
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    output logic        ready,
    output logic        collision,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_write_byte,
    input  logic [7:0]  mem_read_byte
);

`ifdef GPU_WRAP_EN
    localparam logic WRAP = 1'b1;
`else
    localparam logic WRAP = 1'b0;
`endif

    gpu_state_t  state;
    gpu_state_t  state_next;

    logic [15:0] addr_q;
    logic [3:0]  lines_q;
    logic [5:0]  x_q;
    logic [4:0]  y_q;
    logic [3:0]  line_idx;
    logic [7:0]  sprite_q;

    logic [7:0]  left_bits;
    logic [7:0]  right_bits;
    logic [5:0]  row_full;
    logic [4:0]  row;
    logic [2:0]  col;
    logic [2:0]  shift;
    logic        row_clipped;
    logic        no_more_lines;
    logic        last_line;
    logic        do_right;
    logic [15:0] left_addr;
    logic [15:0] right_addr;

    // Upper coordinate bits are ignored by design.
    logic        unused_ok;
    assign unused_ok = &{1'b0, x[7:6], y[7:5], row_full[5]};

    sprite_shifter u_shifter (
        .sprite (sprite_q),
        .shift  (shift),
        .left   (left_bits),
        .right  (right_bits)
    );

    // ------------------------------------------------------------------------
    // Line geometry
    // ------------------------------------------------------------------------
    assign row_full      = {1'b0, y_q} + {2'b00, line_idx};
    assign row           = row_full[4:0];
    assign col           = x_q[5:3];
    assign shift         = x_q[2:0];
    // Rows only increase, so the first clipped line ends the whole draw.
    assign row_clipped   = !WRAP && row_full[5];
    assign no_more_lines = (line_idx == lines_q);
    assign last_line     = ({1'b0, line_idx} + 5'd1) == {1'b0, lines_q};
    assign do_right      = (shift != 3'd0) && (WRAP || (col != 3'd7));
    assign left_addr     = SCREEN_ADDR + {8'h00, row, col};
    assign right_addr    = SCREEN_ADDR + {8'h00, row, col + 3'd1};

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (draw) state_next = ST_FETCH;
            ST_FETCH: state_next = (no_more_lines || row_clipped) ? ST_IDLE : ST_LRD;
            ST_LRD:   state_next = ST_LWR;
            ST_LWR:   state_next = do_right ? ST_RRD : ST_NEXT;
            ST_RRD:   state_next = ST_RWR;
            ST_RWR:   state_next = ST_NEXT;
            ST_NEXT:  state_next = last_line ? ST_IDLE : ST_FETCH;
            default:  state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------------
    always_comb begin
        ready          = (state == ST_IDLE);
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_addr       = 16'h0000;
        mem_write_byte = 8'h00;
        case (state)
            ST_FETCH: begin
                if (!(no_more_lines || row_clipped)) begin
                    mem_read = 1'b1;
                    mem_addr = addr_q + {12'h000, line_idx};
                end
            end
            ST_LRD: begin
                mem_read = 1'b1;
                mem_addr = left_addr;
            end
            ST_LWR: begin
                mem_write      = 1'b1;
                mem_addr       = left_addr;
                mem_write_byte = mem_read_byte ^ left_bits;
            end
            ST_RRD: begin
                mem_read = 1'b1;
                mem_addr = right_addr;
            end
            ST_RWR: begin
                mem_write      = 1'b1;
                mem_addr       = right_addr;
                mem_write_byte = mem_read_byte ^ right_bits;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Request latch, line counter, sprite byte and collision accumulator
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q    <= 16'h0000;
            lines_q   <= 4'd0;
            x_q       <= 6'd0;
            y_q       <= 5'd0;
            line_idx  <= 4'd0;
            sprite_q  <= 8'h00;
            collision <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (draw) begin
                        addr_q    <= addr;
                        lines_q   <= lines;
                        x_q       <= x[5:0];
                        y_q       <= y[4:0];
                        line_idx  <= 4'd0;
                        collision <= 1'b0;
                    end
                end
                ST_LRD:  sprite_q <= mem_read_byte;
                ST_LWR:  if ((mem_read_byte & left_bits) != 8'h00) collision <= 1'b1;
                ST_RWR:  if ((mem_read_byte & right_bits) != 8'h00) collision <= 1'b1;
                ST_NEXT: line_idx <= line_idx + 4'd1;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_chip8_gpu.sv
`default_nettype none
// ============================================================================
// Module      : tb_chip8_gpu
// Description : Scoreboard bench for chip8_gpu. Each draw pushes its expected
//               memory writes and final collision flag into queues; a monitor
//               pops and compares whenever the DUT writes memory or raises
//               ready. A behavioural 1-cycle-latency memory backs the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chip8_gpu;

    localparam logic [15:0] SCR = 16'h0F00;

    logic        clk = 1'b0;
    logic        reset;
    logic        draw;
    logic [15:0] addr;
    logic [3:0]  lines;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        ready;
    logic        collision;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [7:0]  mem_write_byte;
    logic [7:0]  mem_read_byte;

    chip8_gpu #(.SCREEN_ADDR(SCR)) dut (
        .clk            (clk),
        .reset          (reset),
        .draw           (draw),
        .addr           (addr),
        .lines          (lines),
        .x              (x),
        .y              (y),
        .ready          (ready),
        .collision      (collision),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_write_byte (mem_write_byte),
        .mem_read_byte  (mem_read_byte)
    );

    always #5 clk = ~clk;

    // Memory model with a side load port for preloading.
    logic [7:0]  mem [0:65535];
    logic        load_en = 1'b0;
    logic [15:0] load_addr = 16'h0;
    logic [7:0]  load_data = 8'h0;

    always @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
        else if (mem_write) mem[mem_addr] <= mem_write_byte;
        if (mem_read) mem_read_byte <= mem[mem_addr];
    end

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t  wq[$];
    logic cq[$];
    wr_t  exp_w;
    logic exp_c;

    int   checks   = 0;
    int   errors   = 0;
    int   wr_count = 0;
    int   rd_count = 0;
    logic prev_ready = 1'b1;

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        if (mem_read || mem_write) begin
            checks++;
            if (mem_read && mem_write) begin
                errors++;
                $display("FAIL strobe_onehot: read=%0b write=%0b, required at most one", mem_read, mem_write);
            end
        end
        if (mem_read) rd_count++;
        if (mem_write) begin
            wr_count++;
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%h data=%h, required no write", mem_addr, mem_write_byte);
            end else begin
                exp_w = wq.pop_front();
                if (mem_addr !== exp_w.a || mem_write_byte !== exp_w.d) begin
                    errors++;
                    $display("FAIL write: addr=%h data=%h, required addr=%h data=%h",
                             mem_addr, mem_write_byte, exp_w.a, exp_w.d);
                end
            end
        end
        if (!reset && ready && !prev_ready) begin
            checks++;
            if (cq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: collision=%0b, required no completion", collision);
            end else begin
                exp_c = cq.pop_front();
                if (collision !== exp_c) begin
                    errors++;
                    $display("FAIL collision: got %0b, required %0b", collision, exp_c);
                end
            end
        end
        prev_ready = ready;
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic push_w(input logic [15:0] a, input logic [7:0] d);
        wq.push_back({a, d});
    endtask

    // Issues one draw and returns the number of cycles ready stayed low.
    task automatic run_draw(input logic [15:0] a, input logic [3:0] l,
                            input logic [7:0] xx, input logic [7:0] yy,
                            output int busy);
        @(negedge clk);
        addr  = a;
        lines = l;
        x     = xx;
        y     = yy;
        draw  = 1'b1;
        @(negedge clk);
        draw = 1'b0;
        busy = 0;
        while (ready !== 1'b1 && busy < 200) begin
            busy++;
            @(negedge clk);
        end
        checks++;
        if (busy >= 200) begin
            errors++;
            $display("FAIL draw_timeout: busy=%0d cycles, required completion", busy);
        end
        @(negedge clk);
        #1;
        chk("pending_writes", 16'(wq.size()), 16'd0);
    endtask

    int busy;
    int rd0;
    int wr0;
    int n;

    initial begin
        reset = 1'b1;
        draw  = 1'b0;
        addr  = 16'h0;
        lines = 4'd0;
        x     = 8'h0;
        y     = 8'h0;
        repeat (2) @(negedge clk);
        chk("reset_ready", {15'h0, ready}, 16'd1);
        chk("reset_collision", {15'h0, collision}, 16'd0);
        chk("reset_strobes", {14'h0, mem_read, mem_write}, 16'd0);

        for (int i = 0; i < 256; i++) poke(SCR + 16'(i), 8'h00);
        poke(16'h0002, 8'hAA);
        poke(16'h0003, 8'h55);
        reset = 1'b0;

        // Unaligned two-line draw on a blank screen.
        push_w(SCR + 16'h08, 8'h0A); push_w(SCR + 16'h09, 8'hA0);
        push_w(SCR + 16'h10, 8'h05); push_w(SCR + 16'h11, 8'h50);
        cq.push_back(1'b0);
        run_draw(16'h0002, 4'd2, 8'd4, 8'd1, busy);
        chk("busy_unaligned", 16'(busy), 16'd12);
        chk("mem_0f08", {8'h0, mem[SCR + 16'h08]}, 16'h0A);
        chk("mem_0f11", {8'h0, mem[SCR + 16'h11]}, 16'h50);

        // Overlapping draw at x=2.
        push_w(SCR + 16'h08, 8'h20); push_w(SCR + 16'h09, 8'h20);
        push_w(SCR + 16'h10, 8'h10); push_w(SCR + 16'h11, 8'h10);
        cq.push_back(1'b1);
        run_draw(16'h0002, 4'd2, 8'd2, 8'd1, busy);
        chk("mem_0f08_overlap", {8'h0, mem[SCR + 16'h08]}, 16'h20);

        // Aligned single line: one write, 4 cycles with ready low
        // (5 including the accepting cycle).
        wr0 = wr_count;
        push_w(SCR + 16'h51, 8'hAA);
        cq.push_back(1'b0);
        run_draw(16'h0002, 4'd1, 8'd8, 8'd10, busy);
        chk("busy_aligned", 16'(busy), 16'd4);
        chk("writes_aligned", 16'(wr_count - wr0), 16'd1);

        // Same sprite again erases it and collides.
        push_w(SCR + 16'h51, 8'h00);
        cq.push_back(1'b1);
        run_draw(16'h0002, 4'd1, 8'd8, 8'd10, busy);
        chk("mem_0f51_restored", {8'h0, mem[SCR + 16'h51]}, 16'h00);

        // lines=0: no memory traffic, collision cleared.
        rd0 = rd_count;
        wr0 = wr_count;
        cq.push_back(1'b0);
        run_draw(16'h0002, 4'd0, 8'd8, 8'd10, busy);
        chk("zero_lines_reads", 16'(rd_count - rd0), 16'd0);
        chk("zero_lines_writes", 16'(wr_count - wr0), 16'd0);

        // Bottom-right corner.
        push_w(SCR + 16'hFF, 8'h0A);
`ifdef GPU_WRAP_EN
        push_w(SCR + 16'hF8, 8'hA0);
        push_w(SCR + 16'h07, 8'h05);
        push_w(SCR + 16'h00, 8'h50);
`endif
        cq.push_back(1'b0);
        run_draw(16'h0002, 4'd2, 8'd60, 8'd31, busy);
`ifdef GPU_WRAP_EN
        chk("wrap_0f00", {8'h0, mem[SCR + 16'h00]}, 16'h50);
        chk("wrap_0ff8", {8'h0, mem[SCR + 16'hF8]}, 16'hA0);
`else
        chk("clip_0f00", {8'h0, mem[SCR + 16'h00]}, 16'h00);
        chk("clip_0ff8", {8'h0, mem[SCR + 16'hF8]}, 16'h00);
        chk("clip_0f07", {8'h0, mem[SCR + 16'h07]}, 16'h00);
`endif
        chk("corner_0fff", {8'h0, mem[SCR + 16'hFF]}, 16'h0A);

        // Reset asserted while the right-byte write is on the bus.
        push_w(SCR + 16'hA0, 8'h0A);
        push_w(SCR + 16'hA1, 8'hA0);
        wr0 = wr_count;
        @(negedge clk);
        addr  = 16'h0002;
        lines = 4'd1;
        x     = 8'd4;
        y     = 8'd20;
        draw  = 1'b1;
        @(negedge clk);
        draw = 1'b0;
        #1;
        n = 0;
        while (wr_count < wr0 + 2 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL rwr_wait: writes=%0d, required 2", wr_count - wr0);
        end
        reset = 1'b1;
        #1;
        chk("abort_ready", {15'h0, ready}, 16'd1);
        chk("abort_strobes", {14'h0, mem_read, mem_write}, 16'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("abort_left_kept", {8'h0, mem[SCR + 16'hA0]}, 16'h0A);
        chk("abort_right_absent", {8'h0, mem[SCR + 16'hA1]}, 16'h00);

        // Normal draw after the abort.
        push_w(SCR + 16'hA0, 8'h00);
        push_w(SCR + 16'hA1, 8'hA0);
        cq.push_back(1'b1);
        run_draw(16'h0002, 4'd1, 8'd4, 8'd20, busy);
        chk("post_abort_busy", 16'(busy), 16'd6);
        chk("post_abort_0fa1", {8'h0, mem[SCR + 16'hA1]}, 16'hA0);
        chk("pending_collisions", 16'(cq.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
